psum_collect_arb: RTL and testbench
===================================

# psum_collect_arb

Parametrised output-collection stage for a multi-core accumulator array. Captures the concatenated `col`-wide psum vectors of `nch` cores in one register stage and buffers each core's vector in its own first-word-fall-through FIFO of configurable depth. Drains the FIFOs to the host through a valid/ready port, either in lockstep (all channels per beat) or serially (one channel per beat, round-robin). Sits between the core array and the chip output, generalising the fixed two-core, depth-16 output path.

## Interface
- `col`, 8, psum lanes per core
- `bw_psum`, 20, bits per psum lane
- `nch`, 2, number of core channels (≥1)
- `depth`, 16, entries per channel FIFO (power of 2, ≥2)
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `in_data`  in  `nch*col*bw_psum`  core outputs, channel 0 in LSBs
- `wr`  in  1  capture `in_data` this cycle
- `mode`  in  1  0 = lockstep, 1 = serial round-robin
- `out_data`  out  `nch*col*bw_psum`  drained data, zero when `out_valid`=0
- `out_ch`  out  `$clog2(nch)` (min 1)  channel of current serial beat, 0 in lockstep
- `out_valid`  out  1  head data available
- `out_ready`  in  1  host accepts beat
- `full`  out  1  any channel FIFO holds `depth` entries
- `empty`  out  1  all channel FIFOs empty and stage register empty
- `level`  out  `$clog2(depth)+1`  maximum occupancy across channels
- `overflow`  out  1  sticky: a beat was dropped

## Operation
- Stage: `wr`=1 loads `in_data` into `stage_q` and sets `stage_v`. Next cycle `stage_v` pushes the slice of every channel into its FIFO at the same time, then clears (unless `wr` is 1 again).
- Push rule: a beat is accepted only if every channel has room. A channel has room if its count < `depth`, or if it is popped in the same cycle. Otherwise the whole beat is dropped (no partial write) and `overflow` sets. `overflow` clears only on reset.
- Mode latch: `mode_q` loads `mode` only in cycles where `empty`=1. Otherwise it holds its value. All drain behaviour uses `mode_q`.
- Lockstep (`mode_q`=0):
  - `out_valid` = all channels non-empty.
  - `out_data` = the concatenated heads.
  - A handshake (`out_valid & out_ready`) pops every channel.
- Serial (`mode_q`=1):
  - Pointer `rr` selects a channel.
  - `out_valid` = channel `rr` non-empty.
  - `out_data[col*bw_psum-1:0]` = head of `rr`; upper bits are 0.
  - `out_ch` = `rr`.
  - A handshake pops only channel `rr` and advances `rr` to `rr+1`, wrapping `nch-1`→0.
  - `rr` resets to 0 whenever `mode_q` changes.
- Pointer wrap: the FIFO read and write pointers are `$clog2(depth)+1` bits. Full/empty are decided by comparing the MSB and the remaining bits.
- Simultaneous push and pop on a channel: count is unchanged and data ordering is preserved.
- A push into an empty FIFO is visible at the head in the following cycle.

## Timing
- Reset values:
  - `out_data`=0, `out_valid`=0, `out_ch`=0
  - `full`=0, `empty`=1, `level`=0, `overflow`=0
  - `rr`=0, `mode_q`=0, `stage_v`=0
- Latency: `wr` at cycle t → FIFO write at edge ending t+1 → `out_valid` high during t+2 (if it was previously empty).
- `out_valid`, `out_data`, and `out_ch` are combinational from registered state. They do not depend on `out_ready` within the same cycle.
- Throughput: one beat per cycle per direction. A sustained `wr` with `out_ready`=1 never overflows in lockstep mode.
- Reset asserted mid-drain: all FIFO contents are discarded immediately. There is no output activity until a new `wr` arrives.

## Structure
- Package `psum_collect_pkg`:
  - default `col`, `bw_psum`, `nch`, `depth`
  - localparams for the word width `W=col*bw_psum`, the pointer width, and the count width
  - enum for the mode (`LOCKSTEP`, `SERIAL`)
- Sub-module `fifo_sync_fwft`:
  - single-clock first-word-fall-through FIFO, parameters `bw` and `depth`
  - ports: push, pop, din, dout, count, full, empty
  - instantiated `nch` times through a generate loop
- Top level contains: the stage register, the push-admission logic, the `rr` pointer, the mode latch, and the output mux.

## Test plan
- Reset, then lockstep with `nch`=2: `wr` for 3 cycles with ch0=0x1..3, ch1=0x11..13, `out_ready`=1 → from t+2, three beats {0x11,0x1}, {0x12,0x2}, {0x13,0x3}; afterwards `empty`=1.
- Serial with `nch`=2: 2 beats written, `out_ready`=1 → beats in order ch0 0x1, ch1 0x11, ch0 0x2, ch1 0x12, with `out_ch` toggling 0,1,0,1; upper bits of `out_data` are 0.
- Fill with `out_ready`=0, `depth`=16: 16 writes → `full`=1 and `level`=16. A 17th write is dropped and `overflow`=1. Draining returns exactly the first 16 beats.
- At `full`, `wr` and lockstep pop in the same cycle → push accepted, `level` stays 16, `overflow` stays 0.
- Toggle `mode` while `level`=3 → `mode_q` does not change until the drain completes and `empty`=1; `rr` is then 0.
- Assert `reset` asynchronously after 5 beats are queued → `out_valid`=0, `level`=0, `overflow`=0 without waiting for a clock edge. The next `wr` appears at t+2.

Source files
------------

// File: rtl/psum_collect_pkg.sv
// Shared defaults and types for the psum output-collection stage.
package psum_collect_pkg;

  localparam int COL     = 8;
  localparam int BW_PSUM = 20;
  localparam int NCH     = 2;
  localparam int DEPTH   = 16;

  localparam int W     = COL * BW_PSUM;
  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic {
    LOCKSTEP = 1'b0,
    SERIAL   = 1'b1
  } mode_e;

  // A single channel still needs a 1-bit channel index.
  function automatic int rr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_sync_fwft.sv
// Single-clock first-word-fall-through FIFO; head is always visible on dout_o.
module fifo_sync_fwft #(
  parameter int bw    = 160,
  parameter int depth = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [bw-1:0]         din_i,
  output logic [bw-1:0]         dout_o,
  output logic [$clog2(depth):0] count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(depth);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [bw-1:0] mem_q [depth];
  logic          do_push, do_pop;

  // Extra MSB distinguishes a full ring from an empty one.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/psum_collect_arb.sv
// Collects per-core psum vectors into channel FIFOs and drains them to the
// host either all channels per beat or one channel per beat round-robin.
module psum_collect_arb
  import psum_collect_pkg::*;
#(
  parameter int col     = COL,
  parameter int bw_psum = BW_PSUM,
  parameter int nch     = NCH,
  parameter int depth   = DEPTH
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [nch*col*bw_psum-1:0]    in_data_i,
  input  logic                          wr_i,
  input  logic                          mode_i,
  output logic [nch*col*bw_psum-1:0]    out_data_o,
  output logic [rr_width(nch)-1:0]      out_ch_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(depth):0]        level_o,
  output logic                          overflow_o
);

  localparam int WW = col * bw_psum;
  localparam int CW = $clog2(depth) + 1;
  localparam int RW = rr_width(nch);

  logic [nch*WW-1:0] stage_q;
  logic              stage_v_q;
  mode_e             mode_q, mode_d;
  logic [RW-1:0]     rr_q, rr_d;
  logic              overflow_q, overflow_d;

  logic [WW-1:0]     head [nch];
  logic [CW-1:0]     cnt  [nch];
  logic [nch-1:0]    f_full, f_empty, pop, room;
  logic [nch*WW-1:0] lock_data;
  logic [WW-1:0]     sel_head;
  logic              sel_valid, lock_valid, hs, accept;

  for (genvar g = 0; g < nch; g++) begin : g_ch
    fifo_sync_fwft #(.bw(WW), .depth(depth)) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (accept),
      .pop_i   (pop[g]),
      .din_i   (stage_q[g*WW +: WW]),
      .dout_o  (head[g]),
      .count_o (cnt[g]),
      .full_o  (f_full[g]),
      .empty_o (f_empty[g])
    );
    assign lock_data[g*WW +: WW] = head[g];
    assign room[g] = ~f_full[g] | pop[g];
  end

  // Whole beat is admitted or dropped; a same-cycle pop frees a full slot.
  assign accept     = stage_v_q & (&room);
  assign overflow_d = overflow_q | (stage_v_q & ~(&room));

  assign lock_valid = &(~f_empty);
  assign empty_o    = (&f_empty) & ~stage_v_q;
  assign full_o     = |f_full;
  assign overflow_o = overflow_q;

  always_comb begin
    sel_head  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < nch; i++) begin
      if (rr_q == RW'(i)) begin
        sel_head  = head[i];
        sel_valid = ~f_empty[i];
      end
    end
  end

  always_comb begin
    out_valid_o = (mode_q == SERIAL) ? sel_valid : lock_valid;
    hs          = out_valid_o & out_ready_i;
    out_ch_o    = (mode_q == SERIAL) ? rr_q : '0;
    out_data_o  = '0;
    pop         = '0;
    if (mode_q == SERIAL) begin
      if (out_valid_o) out_data_o[WW-1:0] = sel_head;
      for (int i = 0; i < nch; i++) pop[i] = hs && (rr_q == RW'(i));
    end else begin
      if (out_valid_o) out_data_o = lock_data;
      pop = {nch{hs}};
    end
  end

  always_comb begin
    level_o = '0;
    for (int i = 0; i < nch; i++) begin
      if (cnt[i] > level_o) level_o = cnt[i];
    end
  end

  // Mode only changes with nothing in flight, which also restarts the pointer.
  always_comb begin
    mode_d = mode_q;
    rr_d   = rr_q;
    if (empty_o) mode_d = mode_e'(mode_i);
    if (mode_d != mode_q) begin
      rr_d = '0;
    end else if (mode_q == SERIAL && hs) begin
      rr_d = (rr_q == RW'(nch - 1)) ? '0 : rr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stage_q    <= '0;
      stage_v_q  <= 1'b0;
      mode_q     <= LOCKSTEP;
      rr_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_i) stage_q <= in_data_i;
      stage_v_q  <= wr_i;
      mode_q     <= mode_d;
      rr_q       <= rr_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_psum_collect_arb.sv
// Scoreboard bench for psum_collect_arb with nch=2, col=8, bw_psum=20, depth=16.
module tb_psum_collect_arb;

  localparam int NCH = 2;
  localparam int DEPTH = 16;
  localparam int WW = 8 * 20;
  localparam int TW = NCH * WW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [TW-1:0] in_data = '0;
  logic          wr = 1'b0;
  logic          mode = 1'b0;
  logic [TW-1:0] out_data;
  logic [0:0]    out_ch;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          full, empty, overflow;
  logic [4:0]    level;

  typedef struct {
    logic [TW-1:0] data;
    logic          ch;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  psum_collect_arb #(.col(8), .bw_psum(20), .nch(NCH), .depth(DEPTH)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_data_i   (in_data),
    .wr_i        (wr),
    .mode_i      (mode),
    .out_data_o  (out_data),
    .out_ch_o    (out_ch),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .full_o      (full),
    .empty_o     (empty),
    .level_o     (level),
    .overflow_o  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [WW-1:0] c0, input logic [WW-1:0] c1);
    in_data = {c1, c0};
    wr = 1'b1;
  endtask

  task automatic exp_lock(input logic [WW-1:0] c0, input logic [WW-1:0] c1);
    exp_t e;
    e.data = {c1, c0};
    e.ch = 1'b0;
    sb.push_back(e);
  endtask

  task automatic exp_ser(input logic [WW-1:0] c0, input logic [WW-1:0] c1);
    exp_t e;
    e.data = {{WW{1'b0}}, c0};
    e.ch = 1'b0;
    sb.push_back(e);
    e.data = {{WW{1'b0}}, c1};
    e.ch = 1'b1;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d beats still outstanding after %0d cycles, required 0", name, sb.size(), budget);
      sb.delete();
    end
    tick();
  endtask

  // Monitor: every accepted beat is compared against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got data %h ch %0d, required no beat", out_data, out_ch);
        end else begin
          mon_e = sb.pop_front();
          chk("beat_data", out_data, mon_e.data);
          chk("beat_ch", TW'(out_ch), TW'(mon_e.ch));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    chk("rst_out_data", out_data, '0);
    chk("rst_out_valid", TW'(out_valid), '0);
    chk("rst_out_ch", TW'(out_ch), '0);
    chk("rst_full", TW'(full), '0);
    chk("rst_empty", TW'(empty), TW'(1));
    chk("rst_level", TW'(level), '0);
    chk("rst_overflow", TW'(overflow), '0);
    tick();
    reset = 1'b0;
    tick();

    // Lockstep, three beats with latency check
    out_ready = 1'b1;
    set_wr('h1, 'h11); exp_lock('h1, 'h11);
    tick();
    chk("lat_t1_valid", TW'(out_valid), '0);
    set_wr('h2, 'h12); exp_lock('h2, 'h12);
    tick();
    chk("lat_t2_valid", TW'(out_valid), TW'(1));
    set_wr('h3, 'h13); exp_lock('h3, 'h13);
    tick();
    wr = 1'b0;
    wait_drain("lock_drain", 20);
    chk("lock_empty", TW'(empty), TW'(1));

    // Serial round-robin
    mode = 1'b1;
    tick();
    tick();
    set_wr('h1, 'h11); exp_ser('h1, 'h11);
    tick();
    set_wr('h2, 'h12); exp_ser('h2, 'h12);
    tick();
    wr = 1'b0;
    wait_drain("serial_drain", 20);
    chk("serial_empty", TW'(empty), TW'(1));

    // Fill to full in lockstep with the host stalled
    mode = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      set_wr(WW'(k), WW'(k + 'h100));
      exp_lock(WW'(k), WW'(k + 'h100));
      tick();
    end
    wr = 1'b0;
    tick();
    tick();
    chk("fill_full", TW'(full), TW'(1));
    chk("fill_level", TW'(level), TW'(16));
    chk("fill_overflow", TW'(overflow), '0);

    // Write into a full FIFO while the head is popped in the same cycle
    set_wr('d17, 'h111); exp_lock('d17, 'h111);
    tick();
    wr = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fullpop_level", TW'(level), TW'(16));
    chk("fullpop_full", TW'(full), TW'(1));
    chk("fullpop_overflow", TW'(overflow), '0);

    // Write into a full FIFO with no pop is dropped
    set_wr('d18, 'h112);
    tick();
    wr = 1'b0;
    tick();
    tick();
    chk("drop_overflow", TW'(overflow), TW'(1));
    chk("drop_level", TW'(level), TW'(16));
    out_ready = 1'b1;
    wait_drain("fill_drain", 40);
    chk("fill_drain_empty", TW'(empty), TW'(1));
    chk("fill_drain_level", TW'(level), '0);

    // Mode request held off until the queue drains
    out_ready = 1'b0;
    set_wr('h21, 'h31); exp_lock('h21, 'h31);
    tick();
    set_wr('h22, 'h32); exp_lock('h22, 'h32);
    tick();
    set_wr('h23, 'h33); exp_lock('h23, 'h33);
    tick();
    wr = 1'b0;
    tick();
    tick();
    chk("hold_level", TW'(level), TW'(3));
    mode = 1'b1;
    tick();
    tick();
    chk("hold_out_data", out_data, {WW'('h31), WW'('h21)});
    chk("hold_out_ch", TW'(out_ch), '0);
    out_ready = 1'b1;
    wait_drain("hold_drain", 20);
    chk("hold_empty", TW'(empty), TW'(1));
    tick();
    set_wr('h41, 'h51); exp_ser('h41, 'h51);
    tick();
    wr = 1'b0;
    wait_drain("post_switch_drain", 20);

    // Asynchronous reset mid-queue
    mode = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_wr(WW'('h60 + k), WW'('h70 + k));
      tick();
    end
    wr = 1'b0;
    tick();
    tick();
    chk("prerst_level", TW'(level), TW'(5));
    chk("prerst_overflow", TW'(overflow), TW'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", TW'(out_valid), '0);
    chk("arst_level", TW'(level), '0);
    chk("arst_overflow", TW'(overflow), '0);
    chk("arst_empty", TW'(empty), TW'(1));
    chk("arst_out_data", out_data, '0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("postrst_idle_valid", TW'(out_valid), '0);
    out_ready = 1'b1;
    set_wr('h81, 'h91); exp_lock('h81, 'h91);
    tick();
    wr = 1'b0;
    chk("postrst_t1_valid", TW'(out_valid), '0);
    tick();
    chk("postrst_t2_valid", TW'(out_valid), TW'(1));
    wait_drain("postrst_drain", 20);
    chk("final_empty", TW'(empty), TW'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
